// File: rtl/core101_pkg.sv
// Shared definitions for the core101 fetch path.
// Holds the PC-source select encodings, the fetch FSM state type, the
// NOP instruction loaded into the IR at reset and the default XLEN.
package core101_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_RESET  = 2'b11;

    localparam logic [31:0] INS_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_WAIT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select.
// Ports:
//   pc            current PC
//   sel           PC source (seq / branch / jump / reset vector)
//   branch_target branch target address
//   jump_target   jump target address
//   next_pc       selected next PC (sequential path wraps modulo 2^XLEN)
module pc_next_mux
    import core101_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               PC_INC       = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc
);

    always_comb begin
        next_pc = pc + XLEN'(PC_INC);
        case (sel)
            PC_SEL_SEQ:    next_pc = pc + XLEN'(PC_INC);
            PC_SEL_BRANCH: next_pc = branch_target;
            PC_SEL_JUMP:   next_pc = jump_target;
            PC_SEL_RESET:  next_pc = RESET_VECTOR;
            default:       next_pc = pc + XLEN'(PC_INC);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch datapath: PC and IR registers, next-PC select and a
// request/grant/response handshake with instruction memory.
// Ports:
//   fetch_unit_clock_in / fetch_unit_reset_n_in   clock, async active-low reset
//   fetch_unit_pc_set_val_in    load PC from the next-PC mux
//   fetch_unit_ir_set_val_in    start a fetch at the current PC
//   fetch_unit_pc_mux_sel_in    PC source select
//   fetch_unit_branch_target_in / fetch_unit_jump_target_in   PC sources
//   fetch_unit_mem_req_out / _addr_out / _gnt_in / _rvalid_in / _rdata_in
//                               instruction memory port
//   fetch_unit_pc_out / fetch_unit_ir_out   architectural PC and IR
//   fetch_unit_ins_data_out     IR[6:0] opcode to the control unit
//   fetch_unit_ins_valid_out    one-cycle pulse after the IR loads
//   fetch_unit_busy_out         fetch outstanding
//   fetch_unit_fault_out        one-cycle pulse on a misaligned fetch attempt
module fetch_unit
    import core101_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               PC_INC       = 4
) (
    input  logic            fetch_unit_clock_in,
    input  logic            fetch_unit_reset_n_in,
    input  logic            fetch_unit_pc_set_val_in,
    input  logic            fetch_unit_ir_set_val_in,
    input  logic [1:0]      fetch_unit_pc_mux_sel_in,
    input  logic [XLEN-1:0] fetch_unit_branch_target_in,
    input  logic [XLEN-1:0] fetch_unit_jump_target_in,
    output logic            fetch_unit_mem_req_out,
    output logic [XLEN-1:0] fetch_unit_mem_addr_out,
    input  logic            fetch_unit_mem_gnt_in,
    input  logic            fetch_unit_mem_rvalid_in,
    input  logic [31:0]     fetch_unit_mem_rdata_in,
    output logic [XLEN-1:0] fetch_unit_pc_out,
    output logic [31:0]     fetch_unit_ir_out,
    output logic [6:0]      fetch_unit_ins_data_out,
    output logic            fetch_unit_ins_valid_out,
    output logic            fetch_unit_busy_out,
    output logic            fetch_unit_fault_out
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, next_pc, fetch_addr;
    logic [31:0]     ir;
    logic            ins_valid, fault;
    logic            start_fetch, misaligned, load_ir;

    pc_next_mux #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .PC_INC       (PC_INC)
    ) u_pc_next_mux (
        .pc            (pc),
        .sel           (fetch_unit_pc_mux_sel_in),
        .branch_target (fetch_unit_branch_target_in),
        .jump_target   (fetch_unit_jump_target_in),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_next  = state;
        start_fetch = 1'b0;
        misaligned  = 1'b0;
        load_ir     = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (fetch_unit_ir_set_val_in) begin
                    if (pc[1:0] == 2'b00) begin
                        start_fetch = 1'b1;
                        state_next  = FETCH_REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            FETCH_REQ: begin
                if (fetch_unit_mem_gnt_in) begin
                    // Grant and data in the same cycle completes immediately.
                    if (fetch_unit_mem_rvalid_in) begin
                        load_ir    = 1'b1;
                        state_next = FETCH_IDLE;
                    end else begin
                        state_next = FETCH_WAIT;
                    end
                end
            end
            FETCH_WAIT: begin
                if (fetch_unit_mem_rvalid_in) begin
                    load_ir    = 1'b1;
                    state_next = FETCH_IDLE;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge fetch_unit_clock_in or negedge fetch_unit_reset_n_in) begin
        if (!fetch_unit_reset_n_in) begin
            state      <= FETCH_IDLE;
            pc         <= RESET_VECTOR;
            ir         <= INS_NOP;
            fetch_addr <= RESET_VECTOR;
            ins_valid  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state     <= state_next;
            ins_valid <= load_ir;
            fault     <= misaligned;
            // The fetch latches the pre-update PC, so a simultaneous
            // pc_set does not affect the address being fetched.
            if (start_fetch)              fetch_addr <= pc;
            if (fetch_unit_pc_set_val_in) pc         <= next_pc;
            if (load_ir)                  ir         <= fetch_unit_mem_rdata_in;
        end
    end

    assign fetch_unit_mem_req_out   = (state == FETCH_REQ);
    assign fetch_unit_mem_addr_out  = fetch_addr;
    assign fetch_unit_pc_out        = pc;
    assign fetch_unit_ir_out        = ir;
    assign fetch_unit_ins_data_out  = ir[6:0];
    assign fetch_unit_ins_valid_out = ins_valid;
    assign fetch_unit_busy_out      = (state != FETCH_IDLE);
    assign fetch_unit_fault_out     = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver predicts each fetch outcome
// from a PC model and pushes it; a monitor pops and compares on DUT output.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_set = 1'b0, ir_set = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] br = '0, jp = '0;
    logic        mem_req, gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] mem_addr, rdata = '0;
    logic [31:0] pc_o, ir_o;
    logic [6:0]  ins_data;
    logic        ins_valid, busy, fault;

    always #5 clk = ~clk;

    fetch_unit dut (
        .fetch_unit_clock_in         (clk),
        .fetch_unit_reset_n_in       (rst_n),
        .fetch_unit_pc_set_val_in    (pc_set),
        .fetch_unit_ir_set_val_in    (ir_set),
        .fetch_unit_pc_mux_sel_in    (sel),
        .fetch_unit_branch_target_in (br),
        .fetch_unit_jump_target_in   (jp),
        .fetch_unit_mem_req_out      (mem_req),
        .fetch_unit_mem_addr_out     (mem_addr),
        .fetch_unit_mem_gnt_in       (gnt),
        .fetch_unit_mem_rvalid_in    (rvalid),
        .fetch_unit_mem_rdata_in     (rdata),
        .fetch_unit_pc_out           (pc_o),
        .fetch_unit_ir_out           (ir_o),
        .fetch_unit_ins_data_out     (ins_data),
        .fetch_unit_ins_valid_out    (ins_valid),
        .fetch_unit_busy_out         (busy),
        .fetch_unit_fault_out        (fault)
    );

    typedef struct {
        bit          is_fault;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0, checks = 0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] last_ir  = 32'h0000_0013;

    // Responder knobs, set by the driver before each fetch.
    int gcnt = 0, rdly = 0;
    bit together = 0;
    int rcnt = 0;
    bit pend = 0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] s,
                                            input logic [31:0] b, input logic [31:0] j);
        case (s)
            2'd0:    return pc + 32'd4;
            2'd1:    return b;
            2'd2:    return j;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Memory model: grant after gcnt cycles of request, data rdly cycles later
    // (or with the grant when 'together').
    initial begin
        forever begin
            @(negedge clk);
            gnt = 1'b0; rvalid = 1'b0;
            if (mem_req) begin
                if (gcnt > 0) gcnt--;
                else begin
                    gnt = 1'b1;
                    if (together) begin
                        rvalid = 1'b1; rdata = mem_word(mem_addr);
                    end else begin
                        pend = 1'b1; rcnt = rdly; pend_addr = mem_addr;
                    end
                end
            end else if (pend) begin
                if (rcnt > 0) rcnt--;
                else begin
                    rvalid = 1'b1; rdata = mem_word(pend_addr); pend = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (mem_req) begin
                if (expq.size() == 0 || expq[0].is_fault) chk("unexpected_req", 32'd1, 32'd0);
                else chk("mem_addr", mem_addr, expq[0].addr);
            end
            if (ins_valid) begin
                if (expq.size() == 0 || expq[0].is_fault) chk("unexpected_ins_valid", 32'd1, 32'd0);
                else begin
                    chk("ir", ir_o, expq[0].data);
                    chk("ins_data", {25'd0, ins_data}, {25'd0, expq[0].data[6:0]});
                    last_ir = expq[0].data;
                    void'(expq.pop_front());
                end
            end
            if (fault) begin
                if (expq.size() == 0 || !expq[0].is_fault) chk("unexpected_fault", 32'd1, 32'd0);
                else begin
                    chk("fault_ir_kept", ir_o, last_ir);
                    chk("fault_busy", {31'd0, busy}, 32'd0);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic do_pcset(input logic [1:0] s, input logic [31:0] b, input logic [31:0] j);
        @(negedge clk);
        pc_set = 1'b1; sel = s; br = b; jp = j;
        model_pc = next_pc(model_pc, s, b, j);
        @(negedge clk);
        pc_set = 1'b0;
        chk("pc_after_set", pc_o, model_pc);
    endtask

    task automatic do_fetch(input int gd, input int rd, input bit tog, input bit with_set,
                            input bit extra_ir, input bit mid_set);
        exp_t e;
        int   t;
        e.is_fault = (model_pc[1:0] != 2'b00);
        e.addr = model_pc;
        e.data = mem_word(model_pc);
        expq.push_back(e);
        @(negedge clk);
        gcnt = gd; rdly = rd; together = tog;
        ir_set = 1'b1;
        if (with_set) begin
            pc_set = 1'b1; sel = 2'b00;
            model_pc = next_pc(model_pc, 2'b00, br, jp);
        end
        @(negedge clk);
        ir_set = extra_ir; pc_set = 1'b0;
        if (extra_ir) begin
            @(negedge clk);
            ir_set = 1'b0;
        end
        if (mid_set) begin
            @(negedge clk);
            pc_set = 1'b1; sel = 2'b00;
            model_pc = next_pc(model_pc, 2'b00, br, jp);
            @(negedge clk);
            pc_set = 1'b0;
        end
        t = 0;
        while (expq.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (expq.size() != 0) begin
            chk("fetch_timeout", 32'd1, 32'd0);
            expq.delete();
        end
        @(negedge clk);
        chk("busy_after_fetch", {31'd0, busy}, 32'd0);
        chk("pc_after_fetch", pc_o, model_pc);
    endtask

    initial begin
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_ir", ir_o, 32'h0000_0013);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_pc", pc_o, 32'h0);
        chk("rel_ir", ir_o, 32'h0000_0013);
        chk("rel_ins_data", {25'd0, ins_data}, 32'h13);
        chk("rel_req", {31'd0, mem_req}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_pulses", {30'd0, ins_valid, fault}, 32'd0);

        // PC source sequence and wrap.
        do_pcset(2'b01, 32'h1C, 32'h0);
        do_pcset(2'b00, 32'h0, 32'h0);
        do_pcset(2'b01, 32'h200, 32'h0);
        do_pcset(2'b10, 32'h0, 32'h3FC);
        do_pcset(2'b11, 32'h0, 32'h0);
        do_pcset(2'b01, 32'hFFFF_FFFC, 32'h0);
        do_pcset(2'b00, 32'h0, 32'h0);

        // Basic fetch at 0x100: grant next cycle, data one cycle later.
        do_pcset(2'b01, 32'h100, 32'h0);
        do_fetch(0, 0, 0, 0, 0, 0);
        chk("ir_0x100", ir_o, 32'h00A0_0093);
        // Grant held off 3 cycles, second ir_set ignored.
        do_fetch(3, 0, 0, 0, 1, 0);
        // Grant and data together.
        do_fetch(0, 0, 1, 0, 0, 0);
        // pc_set with ir_set, then pc_set during WAIT.
        do_pcset(2'b01, 32'h40, 32'h0);
        do_fetch(0, 3, 0, 1, 0, 1);
        chk("pc_0x48", pc_o, 32'h48);
        // Misaligned jump target.
        do_pcset(2'b10, 32'h0, 32'h102);
        do_fetch(0, 0, 0, 0, 0, 0);

        // Random mix.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] rb, rj;
            rb = $urandom & 32'hFFFF_FFFC;
            rj = $urandom;
            if ($urandom_range(0, 3) != 0) rj[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1)
                do_pcset(2'($urandom_range(0, 3)), rb, rj);
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
        end

        // Async reset mid-WAIT; the late response must be ignored.
        do_pcset(2'b01, 32'h80, 32'h0);
        begin
            exp_t e;
            e.is_fault = 0; e.addr = 32'h80; e.data = mem_word(32'h80);
            expq.push_back(e);
        end
        @(negedge clk);
        gcnt = 0; rdly = 4; together = 0; ir_set = 1'b1;
        @(negedge clk);
        ir_set = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, mem_req}, 32'd0);
        chk("async_busy_drop", {31'd0, busy}, 32'd0);
        expq.delete();
        model_pc = 32'h0;
        last_ir = 32'h0000_0013;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("stray_rvalid_ir", ir_o, 32'h0000_0013);
        chk("post_rst_pc", pc_o, 32'h0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch datapath block that carries out the fetch control signals produced by the control-unit state machine. It holds the PC and IR and chooses the next PC from the PC-source select. It runs a request/grant/response handshake with instruction memory and returns the fetched instruction's opcode field (bits [6:0]) to the control unit. It sits between the control unit and the instruction memory port.

Parameters:
XLEN, 32, width of the PC and of address/target buses
RESET_VECTOR, 32'h0000_0000, PC value after reset and for select 2'b11
PC_INC, 4, byte increment applied for sequential fetch

Ports:
fetch_unit_clock_in  input  1  core clock, rising-edge active
fetch_unit_reset_n_in  input  1  asynchronous, active-low reset
fetch_unit_pc_set_val_in  input  1  load the PC from the next-PC mux this cycle
fetch_unit_ir_set_val_in  input  1  start a fetch at the current PC; IR loads on response
fetch_unit_pc_mux_sel_in  input  2  PC source: 00 PC+PC_INC, 01 branch target, 10 jump target, 11 RESET_VECTOR
fetch_unit_branch_target_in  input  XLEN  branch target address
fetch_unit_jump_target_in  input  XLEN  jump target address
fetch_unit_mem_req_out  output  1  instruction memory request
fetch_unit_mem_addr_out  output  XLEN  request address; stable while the request is pending
fetch_unit_mem_gnt_in  input  1  memory accepted the request
fetch_unit_mem_rvalid_in  input  1  read data valid
fetch_unit_mem_rdata_in  input  32  read data
fetch_unit_pc_out  output  XLEN  current PC
fetch_unit_ir_out  output  32  instruction register
fetch_unit_ins_data_out  output  7  IR[6:0], the opcode to the control unit
fetch_unit_ins_valid_out  output  1  one-cycle pulse when the IR has just loaded
fetch_unit_busy_out  output  1  fetch outstanding (state is not IDLE)
fetch_unit_fault_out  output  1  one-cycle pulse: fetch refused because the PC is misaligned

Behaviour:
- Reset (async, while fetch_unit_reset_n_in=0):
  - state=IDLE, PC=RESET_VECTOR, IR=32'h0000_0013 (NOP), so ins_data=7'h13.
  - fetch_addr=RESET_VECTOR; ins_valid=0, fault=0, mem_req=0.
- mem_req_out is decoded from state (state==REQ), so an async reset drops it immediately.
- FSM states are IDLE, REQ, WAIT.
- IDLE:
  - ir_set=1 and PC[1:0]==0 → fetch_addr<=PC, go to REQ.
  - ir_set=1 and PC[1:0]!=0 → stay in IDLE, fault pulses the next cycle, no request issued.
- REQ:
  - mem_req=1, mem_addr=fetch_addr.
  - gnt=0 → stay in REQ; address and request held.
  - gnt=1 and rvalid=0 → go to WAIT.
  - gnt=1 and rvalid=1 → IR<=rdata, ins_valid pulses, go to IDLE.
- WAIT:
  - rvalid=1 → IR<=rdata, ins_valid pulses, go to IDLE.
  - gnt is ignored.
- Latency:
  - Minimum 2 cycles from ir_set to IR update (gnt in the first REQ cycle, rvalid the next).
  - 1 cycle if gnt and rvalid arrive together.
- ir_set while busy is ignored; no queueing.
- rvalid in IDLE is ignored, which covers stray responses after a reset.
- pc_set is accepted in any state. PC<=mux(sel) on that edge:
  - 00: PC+PC_INC, modulo 2^XLEN (wraps to 0 from all-ones).
  - 01: branch target. 10: jump target. 11: RESET_VECTOR.
- An outstanding fetch uses fetch_addr, never the live PC, so a PC update during REQ or WAIT does not disturb it.
- pc_set and ir_set together in IDLE: the fetch uses the pre-update PC and the PC updates on the same edge.
- Misaligned targets are loaded into the PC as given; the fault appears only when a fetch is attempted.
- ins_valid and fault are registered and high for exactly one cycle.

Decomposition:
- Shared package core101_pkg holds:
  - PC_SEL_SEQ=2'b00, PC_SEL_BRANCH=2'b01, PC_SEL_JUMP=2'b10, PC_SEL_RESET=2'b11.
  - Fetch FSM encodings IDLE/REQ/WAIT.
  - INS_NOP=32'h0000_0013, XLEN default.
- One sub-module is natural: pc_next_mux, the combinational 4:1 next-PC select with the PC_INC adder.
- The FSM, PC, IR and fetch_addr registers stay in fetch_unit.

Test Plan:
- Reset, then release → PC=0, IR=0x00000013, ins_data=0x13, mem_req=0, busy=0. Assert reset mid-WAIT → mem_req and busy drop asynchronously; a later rvalid leaves IR unchanged.
- ir_set at PC=0x100; gnt the next cycle; rvalid with rdata=0x00A00093 one cycle later → mem_addr=0x100 throughout the request; IR=0x00A00093, ins_data=0x13, ins_valid high for 1 cycle.
- ir_set with gnt held low for 3 cycles → mem_req and mem_addr stable for 4 cycles; a second ir_set during the wait is ignored; exactly one ins_valid pulse.
- pc_set with sel 00 at PC=0x1C, then sel 01 (branch=0x200), then 10 (jump=0x3FC), then 11 → PC=0x20, 0x200, 0x3FC, RESET_VECTOR. With sel 00 at PC=0xFFFFFFFC → PC=0x0.
- pc_set and ir_set together at PC=0x40, sel 00 → mem_addr=0x40, PC=0x44. A further pc_set during WAIT → mem_addr stays 0x40.
- Jump target 0x102, then ir_set → no mem_req, fault pulses for 1 cycle, IR unchanged, busy stays 0.
